// File: rtl/rgb_mixer_pkg.sv
// Shared types and default widths for the RGB PWM mixer.
package rgb_mixer_pkg;

    localparam int CW_DEF = 4;
    localparam int DW_DEF = 5;

    typedef enum logic [1:0] {CH_R, CH_G, CH_B, CH_INV} chan_e;

    typedef enum logic {IDLE, ARMED} cfg_state_e;

    // Phase offset of a channel's compare point: R=0, G=quarter period, B=half period.
    function automatic int unsigned phase_off(input int ch, input int cw);
        if (ch == 1) return 1 << (cw - 2);
        if (ch == 2) return 1 << (cw - 1);
        return 0;
    endfunction

endpackage

// File: rtl/rgb_pwm_mixer_pwm_channel.sv
// One PWM lane: active duty register plus registered comparator against a
// phase-shifted copy of the period count.
module pwm_channel #(
    parameter int CW = 4,
    parameter int DW = CW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] duty_i,
    input  logic [CW-1:0] count_i,
    input  logic [CW-1:0] offset_i,
    output logic          pwm_o
);

    logic [DW-1:0] active_q;
    logic          pwm_q;
    logic [CW-1:0] phase;

    // Wraps naturally mod 2^CW.
    assign phase = count_i + offset_i;
    assign pwm_o = pwm_q;

    // Active duty only changes on load; compare uses the pre-load duty in the
    // load cycle, so the new duty first applies at the next count==0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            if (load_i) active_q <= duty_i;
            pwm_q <= (DW'(phase) < active_q);
        end
    end

endmodule

// File: rtl/rgb_pwm_mixer.sv
// Three-channel PWM mixer with staged duty writes committed at period end.
// Optional: define PWM_PHASE_STAGGER_EN to offset G/B compares by 1/4 and 1/2
// period, spreading the rising edges apart.
module rgb_pwm_mixer
    import rgb_mixer_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = CW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_chan,
    input  logic [DW-1:0] cfg_duty,
    input  logic          cfg_commit,
    output logic          cfg_err,
    output logic          commit_done,
    output logic          pwm_r,
    output logic          pwm_g,
    output logic          pwm_b
);

    localparam logic [CW-1:0] CNT_MAX = '1;

`ifdef PWM_PHASE_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    cfg_state_e           state_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 done_q;
    logic [2:0][DW-1:0]   stage_q;
    logic [2:0]           pwm_w;
    logic                 swap;

    // Swap happens on the last count of a period so count==0 sees the new duty.
    assign swap        = (state_q == ARMED) && (count == CNT_MAX);
    assign cfg_ready   = ready_q;
    assign cfg_err     = err_q;
    assign commit_done = done_q;
    assign pwm_r       = pwm_w[0];
    assign pwm_g       = pwm_w[1];
    assign pwm_b       = pwm_w[2];

    // Config FSM: staging writes while IDLE, wait for period end while ARMED.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid && ready_q) begin
                        if (chan_e'(cfg_chan) == CH_INV) begin
                            err_q <= 1'b1;
                        end else begin
                            for (int i = 0; i < 3; i++)
                                if (cfg_chan == 2'(i)) stage_q[i] <= cfg_duty;
                        end
                    end
                    // A same-cycle write lands above, so it rides along in the commit.
                    if (cfg_commit) begin
                        state_q <= ARMED;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (count == CNT_MAX) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        localparam logic [CW-1:0] OFF = STAGGER ? CW'(phase_off(i, CW)) : '0;

        pwm_channel #(.CW(CW), .DW(DW)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .load_i   (swap),
            .duty_i   (stage_q[i]),
            .count_i  (count),
            .offset_i (OFF),
            .pwm_o    (pwm_w[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_mixer.sv
// Self-checking bench for rgb_pwm_mixer (CW=4) against a cycle-level
// behavioural model of the staging/active duty rules.
module tb_rgb_pwm_mixer;

    localparam int CW = 4;
    localparam int DW = 5;
    localparam int PER = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] count = '0;
    logic          cnt_rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_commit = 1'b0;
    logic [1:0]    cfg_chan = '0;
    logic [DW-1:0] cfg_duty = '0;
    logic          cfg_ready, cfg_err, commit_done, pwm_r, pwm_g, pwm_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int stg[3];
    int act[3];
    int off[3];
    bit armed;
    bit e_ready, e_err, e_done;
    bit e_pwm[3];

    always #5 clk = ~clk;

    // Upstream free-running counter, advanced away from the active edge.
    always @(negedge clk) begin
        if (cnt_rst) count = '0;
        else         count = count + 1'b1;
    end

    rgb_pwm_mixer #(.CW(CW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_duty    (cfg_duty),
        .cfg_commit  (cfg_commit),
        .cfg_err     (cfg_err),
        .commit_done (commit_done),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b)
    );

    // Advance one clock and step the model with what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                stg[i] = 0; act[i] = 0; e_pwm[i] = 1'b0;
            end
            armed = 1'b0; e_ready = 1'b0; e_err = 1'b0; e_done = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                e_pwm[i] = (((int'(count) + off[i]) % PER) < act[i]);
            e_err = 1'b0;
            e_done = 1'b0;
            if (!armed) begin
                if (cfg_valid && e_ready) begin
                    if (cfg_chan == 2'd3) e_err = 1'b1;
                    else                  stg[cfg_chan] = int'(cfg_duty);
                end
                if (cfg_commit) armed = 1'b1;
            end else if (count == 4'd15) begin
                for (int i = 0; i < 3; i++) act[i] = stg[i];
                armed = 1'b0;
                e_done = 1'b1;
            end
            e_ready = !armed;
        end
    endtask

    function automatic int diff();
        return int'(pwm_r !== e_pwm[0] || pwm_g !== e_pwm[1] || pwm_b !== e_pwm[2] ||
                    cfg_ready !== e_ready || commit_done !== e_done || cfg_err !== e_err);
    endfunction

    task automatic write_cfg(input int ch, input int d);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_duty  = DW'(d);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Commit, wait for the swap, then measure high cycles over one full period.
    task automatic run_commit(output int hr, output int hg, output int hb,
                              output int bad, output bit got);
        hr = 0; hg = 0; hb = 0; bad = 0; got = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        bad += diff();
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            bad += diff();
            if (commit_done === 1'b1) got = 1'b1;
        end
        if (got) begin
            for (int k = 0; k < PER; k++) begin
                tick();
                bad += diff();
                hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({pwm_r, pwm_g, pwm_b, cfg_ready, commit_done, cfg_err} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold: got pwm=%b%b%b rdy=%b done=%b err=%b, want all 0",
                         pwm_r, pwm_g, pwm_b, cfg_ready, commit_done, cfg_err);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({pwm_r, pwm_g, pwm_b, commit_done} !== 4'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got pwm=%b%b%b rdy=%b done=%b, want pwm=000 rdy=1 done=0",
                     pwm_r, pwm_g, pwm_b, cfg_ready, commit_done);
        end
    endtask

    task automatic test_commit();
        int bad = 0, dones = 0, hr = 0, hg = 0, hb = 0;
        bit got = 1'b0;
        write_cfg(0, 4);
        write_cfg(1, 8);
        write_cfg(2, 16);
        for (int k = 0; k < 20; k++) begin
            tick(); bad += diff();
            if (count == 4'd4) break;
        end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        bad += diff();
        for (int k = 0; k < 40 && !got; k++) begin
            tick(); bad += diff();
            if ({pwm_r, pwm_g, pwm_b} !== 3'b0 && commit_done !== 1'b1) bad++;
            if (commit_done === 1'b1) begin got = 1'b1; dones++; end
        end
        checks++;
        if (!got || count != 4'd15) begin
            errors++;
            $display("FAIL commit_timing: got done=%0d at count=%0d, want done at count=15", got, count);
        end
        for (int k = 0; k < PER; k++) begin
            tick(); bad += diff();
            dones += int'(commit_done);
            hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL commit_done_once: got %0d pulses, want 1", dones);
        end
        checks++;
        if (hr != 4 || hg != 8 || hb != 16) begin
            errors++;
            $display("FAIL commit_duty: got r=%0d g=%0d b=%0d, want 4 8 16", hr, hg, hb);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL commit_model: got %0d cycle mismatches, want 0", bad);
        end
    endtask

    task automatic test_armed_hold();
        int bad = 0, hr = 0;
        bit rdy, seen_done = 1'b0, acc = 1'b0, early = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        bad += diff();
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_duty = 5'd2;
        for (int k = 0; k < 40 && !acc; k++) begin
            rdy = cfg_ready;
            if (rdy && !seen_done) early = 1'b1;
            tick(); bad += diff();
            if (commit_done === 1'b1) seen_done = 1'b1;
            if (rdy) acc = 1'b1;
        end
        cfg_valid = 1'b0;
        checks++;
        if (!acc || early) begin
            errors++;
            $display("FAIL armed_hold: got accepted=%0d early=%0d, want accepted=1 early=0", acc, early);
        end
        for (int k = 0; k < PER; k++) begin
            tick(); bad += diff();
            hr += int'(pwm_r);
        end
        checks++;
        if (hr != 4 || bad != 0) begin
            errors++;
            $display("FAIL armed_keep: got r=%0d mism=%0d, want r=4 mism=0", hr, bad);
        end
    endtask

    task automatic test_err();
        int bad, hr, hg, hb;
        bit got;
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_duty = 5'd7;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: got %b, want 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b, want 0", cfg_err);
        end
        run_commit(hr, hg, hb, bad, got);
        checks++;
        if (!got || hr != 2 || hg != 8 || hb != 16 || bad != 0) begin
            errors++;
            $display("FAIL err_staging: got done=%0d r=%0d g=%0d b=%0d mism=%0d, want 1 2 8 16 0",
                     got, hr, hg, hb, bad);
        end
    endtask

    task automatic test_zero_full();
        int bad, hr, hg, hb;
        bit got;
        write_cfg(0, 0);
        run_commit(hr, hg, hb, bad, got);
        checks++;
        if (!got || hr != 0 || bad != 0) begin
            errors++;
            $display("FAIL duty_zero: got done=%0d r=%0d mism=%0d, want 1 0 0", got, hr, bad);
        end
        write_cfg(0, 16);
        run_commit(hr, hg, hb, bad, got);
        checks++;
        if (!got || hr != 16 || bad != 0) begin
            errors++;
            $display("FAIL duty_full: got done=%0d r=%0d mism=%0d, want 1 16 0", got, hr, bad);
        end
    endtask

    task automatic test_cnt_rst();
        int bad = 0, n = 0;
        bit got = 1'b0;
        write_cfg(1, 3);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(); bad += diff();
            if (count == 4'd10) break;
        end
        cnt_rst = 1'b1;
        @(negedge clk);
        #1;
        cnt_rst = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick(); bad += diff(); n++;
            if (commit_done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != 16 || bad != 0) begin
            errors++;
            $display("FAIL cnt_rst_wait: got done=%0d after %0d cycles mism=%0d, want 1 16 0", got, n, bad);
        end
    endtask

    task automatic test_random();
        int bad, hr, hg, hb;
        bit got;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 4)) write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 7)) tick();
            run_commit(hr, hg, hb, bad, got);
            checks++;
            if (!got || bad != 0 || hr != ((act[0] < PER) ? act[0] : PER) ||
                hg != ((act[1] < PER) ? act[1] : PER) || hb != ((act[2] < PER) ? act[2] : PER)) begin
                errors++;
                $display("FAIL random_%0d: got done=%0d r=%0d g=%0d b=%0d mism=%0d, want duties %0d %0d %0d (sat 16)",
                         r, got, hr, hg, hb, bad, act[0], act[1], act[2]);
            end
        end
    endtask

    task automatic test_reset_armed();
        int bad = 0, dones = 0, highs = 0;
        write_cfg(0, 5);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (count == 4'd8) break;
        end
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_armed_idle: got rdy=%b, want 1", cfg_ready);
        end
        for (int k = 0; k < 40; k++) begin
            tick(); bad += diff();
            dones += int'(commit_done);
            highs += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
        end
        checks++;
        if (dones != 0 || highs != 0 || bad != 0) begin
            errors++;
            $display("FAIL rst_armed_discard: got done=%0d highs=%0d mism=%0d, want 0 0 0", dones, highs, bad);
        end
    endtask

    initial begin
`ifdef PWM_PHASE_STAGGER_EN
        off = '{0, 4, 8};
`else
        off = '{0, 0, 0};
`endif
        for (int i = 0; i < 3; i++) begin stg[i] = 0; act[i] = 0; e_pwm[i] = 1'b0; end
        armed = 1'b0; e_ready = 1'b0; e_err = 1'b0; e_done = 1'b0;
        test_reset();
        test_commit();
        test_armed_hold();
        test_err();
        test_zero_full();
        test_cnt_rst();
        test_random();
        test_reset_armed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rgb_pwm_mixer.md
Name: rgb_pwm_mixer

Overview:
- Downstream consumer of the free-running 4-bit period counter.
- Compares the counter value against three per-channel duty values and drives registered R/G/B PWM outputs.
- Duty values are written into staging registers over a valid/ready config port.
- Staged values are committed to the active registers only at a period boundary, so PWM edges never glitch mid-period.

Parameters:
- CW, 4, width of the incoming count; one PWM period = 2^CW cycles.
- DW, CW+1, duty width. Extra MSB allows 100% on.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- count  in  CW  free-running period count from the upstream counter; increments once per clk.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a config write.
- cfg_chan  in  2  channel select: 0=R, 1=G, 2=B, 3=invalid.
- cfg_duty  in  DW  duty value for the selected channel.
- cfg_commit  in  1  one-cycle pulse; schedule transfer of staging to active at the next boundary.
- cfg_err  out  1  one-cycle pulse when a write with cfg_chan=3 is accepted.
- commit_done  out  1  one-cycle pulse in the cycle after the staging-to-active swap.
- pwm_r, pwm_g, pwm_b  out  1  registered PWM outputs.

Behaviour:
- Reset (reset=0 at posedge):
  - staging and active duty registers = 0.
  - FSM = IDLE; pwm_* = 0; cfg_err = 0; commit_done = 0.
  - cfg_ready = 0 during reset, 1 in the first cycle after release.
  - Reset asserted mid-ARMED discards the pending commit.
- FSM states:
  - IDLE: cfg_ready=1. A write (cfg_valid && cfg_ready) stores cfg_duty into staging[cfg_chan] at the edge. cfg_commit=1 → ARMED.
  - ARMED: cfg_ready=0; writes are not accepted and the initiator holds cfg_valid. cfg_commit is ignored. At the edge where count == 2^CW-1: active <= staging (all three channels at once), FSM → IDLE, commit_done=1 for the following cycle.
- Simultaneous cfg_valid, cfg_ready and cfg_commit in IDLE: the write lands in staging first and is included in the commit.
- cfg_chan=3: the handshake completes, no register changes, cfg_err pulses for one cycle.
- PWM, per channel x:
  - pwm_x <= (zero-extended count < active_x) on every edge; 1-cycle latency from count.
  - duty 0 → constantly 0.
  - duty 2^CW or above → constantly 1.
  - duty d → high for d cycles per period, starting at count==0.
- Boundary: the swap at count==MAX makes count==0 of the next period the first compare against the new duty. No mixed-duty period occurs.
- If the upstream counter is reset while ARMED, the commit waits for the next count==MAX.

Optional Feature:
- Macro PWM_PHASE_STAGGER_EN.
- When defined: the G compare uses count + 2^(CW-2) and the B compare uses count + 2^(CW-1), both mod 2^CW. R is unchanged. This spreads rising edges to cut simultaneous switching current. Commit timing still keys on the raw count==MAX.
- When undefined: all channels compare against raw count and rise together at count==0.

Decomposition:
- Package rgb_mixer_pkg holds:
  - channel enum chan_e {CH_R, CH_G, CH_B, CH_INV};
  - FSM enum cfg_state_e {IDLE, ARMED};
  - default widths CW_DEF=4 and DW_DEF=5.
- One sub-module, pwm_channel: holds the active duty register and registered comparator, with optional phase offset input. Instantiated three times.

Test Plan (CW=4):
- Reset for 3 cycles, then release → all pwm_*=0, cfg_ready=1, commit_done=0.
- Write R=4, G=8, B=16, then commit while count=5:
  - outputs unchanged until count wraps;
  - commit_done pulses once after the count==15 edge;
  - per 16-cycle period: pwm_r high 4, pwm_g high 8, pwm_b high 16 (constant 1).
- While ARMED, hold cfg_valid with R=2 → cfg_ready=0 until the swap; the write is accepted in the first IDLE cycle; active R stays 4 until the next commit.
- Write cfg_chan=3, duty=7 → cfg_err pulses one cycle; staging for all channels unchanged.
- Commit R=0, then later R=16 → pwm_r constantly 0, then constantly 1 from count==0 of the period after the second swap.
- Assert reset while ARMED at count=9 → after release, FSM is IDLE, active duties are 0, no commit_done.
